// File: rtl/encoder16x4_scan.sv
// encoder16x4_scan: sequential 16-to-4 priority encoder that emits each set bit's index over a valid/ready handshake
module encoder16x4_scan #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] in_vec,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  code,
    output logic        busy,
    output logic        zero,
    output logic        done
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] pending, pending_d, remain;
    logic [3:0]  code_d;
    logic        valid_d, busy_d, zero_d, done_d;
    logic        start, zload, accept, abort, last;

    // Last assignment wins, so the scan direction picks MSB-first or LSB-first.
    function automatic logic [3:0] prio(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        if (HIGH_FIRST)
            for (int i = 0; i < 16; i++) begin
                if (v[i]) r = 4'(i);
            end
        else
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) r = 4'(i);
            end
        return r;
    endfunction

    assign start  = state == IDLE && enable && load && |in_vec;
    assign zload  = state == IDLE && enable && load && !(|in_vec);
    assign abort  = state == EMIT && !enable;
    assign accept = state == EMIT && enable && out_ready;
    assign remain = pending & ~(16'(1) << code);
    assign last   = accept && remain == '0;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // Next state: start a scan on a non-empty load; leave on abort or final accept
    always_comb
        state_nxt = state == IDLE ? (start ? EMIT : IDLE) : ((abort || last) ? IDLE : EMIT);

    // Next values of the registered outputs and the pending vector
    always_comb begin
        pending_d = start ? in_vec : abort ? '0 : accept ? remain : pending;
        code_d    = start ? prio(in_vec) : (accept && !last) ? prio(remain) : code;
        valid_d   = state_nxt == EMIT;
        busy_d    = state_nxt == EMIT;
        zero_d    = zload;
        done_d    = zload || last;
    end

    // Output and pending registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending   <= '0;
            code      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pending   <= pending_d;
            code      <= code_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            zero      <= zero_d;
            done      <= done_d;
        end
endmodule

// File: tb/tb_encoder16x4_scan.sv
// tb_encoder16x4_scan: checks both priority orders against a queue-based model plus directed literals
module tb_encoder16x4_scan;
    logic        clk = 1'b0, rst_n, en, load, rdy;
    logic [15:0] vec;
    logic        ov_h, busy_h, zero_h, done_h, ov_l, busy_l, zero_l, done_l;
    logic [3:0]  code_h, code_l;
    int          tests = 0, fails = 0;

    int   lst[$];
    int   n;
    logic mv, md, mz;

    encoder16x4_scan #(.HIGH_FIRST(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .enable(en), .load(load), .in_vec(vec), .out_ready(rdy),
        .out_valid(ov_h), .code(code_h), .busy(busy_h), .zero(zero_h), .done(done_h));

    encoder16x4_scan #(.HIGH_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .enable(en), .load(load), .in_vec(vec), .out_ready(rdy),
        .out_valid(ov_l), .code(code_l), .busy(busy_l), .zero(zero_l), .done(done_l));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: list of set indices from high to low; high-first walks it forward, low-first backward
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lst.delete(); n = 0; mv = 0; md = 0; mz = 0;
        end else begin
            md = 0; mz = 0;
            if (!mv) begin
                if (en && load) begin
                    lst.delete(); n = 0;
                    for (int i = 15; i >= 0; i--) if (vec[i]) lst.push_back(i);
                    if (lst.size() == 0) begin mz = 1; md = 1; end
                    else mv = 1;
                end
            end else if (!en) mv = 0;
            else if (rdy) begin
                n++;
                if (n == lst.size()) begin mv = 0; md = 1; end
            end
        end

    always @(negedge clk)
        if (rst_n) begin
            chk("valid_hi", 16'(ov_h), 16'(mv));
            chk("valid_lo", 16'(ov_l), 16'(mv));
            chk("busy_hi", 16'(busy_h), 16'(mv));
            chk("busy_lo", 16'(busy_l), 16'(mv));
            chk("done_hi", 16'(done_h), 16'(md));
            chk("done_lo", 16'(done_l), 16'(md));
            chk("zero_hi", 16'(zero_h), 16'(mz));
            chk("zero_lo", 16'(zero_l), 16'(mz));
            if (mv) begin
                chk("code_hi", 16'(code_h), 16'(lst[n]));
                chk("code_lo", 16'(code_l), 16'(lst[lst.size() - 1 - n]));
            end
        end

    initial begin
        rst_n = 0; en = 0; load = 0; vec = '0; rdy = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 16'({ov_h, ov_l}), 16'h0);
        chk("rst_code", 16'({code_h, code_l}), 16'h0);
        chk("rst_flags", 16'({busy_h, zero_h, done_h, busy_l, zero_l, done_l}), 16'h0);
        rst_n = 1;
        // 8421 streamed with ready held high
        en = 1; load = 1; vec = 16'h8421; rdy = 1;
        @(negedge clk); load = 0;
        chk("t2_c0_hi", 16'(code_h), 16'hF); chk("t2_c0_lo", 16'(code_l), 16'h0);
        @(negedge clk);
        chk("t2_c1_hi", 16'(code_h), 16'hA); chk("t2_c1_lo", 16'(code_l), 16'h5);
        @(negedge clk);
        chk("t2_c2_hi", 16'(code_h), 16'h5); chk("t2_c2_lo", 16'(code_l), 16'hA);
        @(negedge clk);
        chk("t2_c3_hi", 16'(code_h), 16'h0); chk("t2_c3_lo", 16'(code_l), 16'hF);
        @(negedge clk);
        chk("t2_done", 16'({done_h, ov_h, busy_h}), 16'b100);
        @(negedge clk);
        chk("t2_done_gone", 16'(done_h), 16'h0);
        // 8421 with a 3-cycle stall on the first code
        load = 1; rdy = 0;
        @(negedge clk); load = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold", 16'({ov_l, code_l}), 16'h10);
            @(negedge clk);
        end
        chk("t3_hold_end", 16'({ov_l, code_l}), 16'h10);
        rdy = 1;
        @(negedge clk); chk("t3_c1_lo", 16'(code_l), 16'h5);
        @(negedge clk); chk("t3_c2_lo", 16'(code_l), 16'hA);
        @(negedge clk); chk("t3_c3_lo", 16'(code_l), 16'hF);
        @(negedge clk); chk("t3_done", 16'({done_l, ov_l}), 16'b10);
        // all-zero vector
        load = 1; vec = 16'h0000;
        @(negedge clk); load = 0;
        chk("t4_pulse", 16'({zero_h, done_h, ov_h, zero_l, done_l, ov_l}), 16'b110110);
        @(negedge clk);
        chk("t4_clear", 16'({zero_h, done_h, ov_h}), 16'h0);
        // FFFF with an ignored load mid-scan
        load = 1; vec = 16'hFFFF;
        @(negedge clk); load = 0;
        for (int i = 0; i < 16; i++) begin
            chk("t5_hi", 16'(code_h), 16'(15 - i));
            chk("t5_lo", 16'(code_l), 16'(i));
            if (i == 4) begin load = 1; vec = 16'h0001; end
            else load = 0;
            @(negedge clk);
        end
        chk("t5_done", 16'({done_h, ov_h}), 16'b10);
        @(negedge clk);
        chk("t5_no_extra", 16'({ov_h, ov_l, done_h}), 16'h0);
        // abort after the second code of 00F0, then reload
        load = 1; vec = 16'h00F0;
        @(negedge clk); load = 0;
        chk("t6_c0", 16'({code_h, code_l}), 16'h74);
        @(negedge clk);
        chk("t6_c1", 16'({code_h, code_l}), 16'h65);
        en = 0;
        @(negedge clk);
        chk("t6_abort", 16'({ov_h, busy_h, done_h, ov_l, busy_l, done_l}), 16'h0);
        en = 1; load = 1; vec = 16'h0002;
        @(negedge clk); load = 0;
        chk("t6_reload", 16'({ov_h, code_h, code_l}), 16'h111);
        @(negedge clk);
        chk("t6_done", 16'({done_h, ov_h, done_l, ov_l}), 16'b1010);
        // async reset in the middle of a scan
        load = 1; vec = 16'hFFFF; rdy = 0;
        @(negedge clk); load = 0;
        chk("t1_active", 16'({ov_h, code_h}), 16'h1F);
        #3 rst_n = 0;
        #1;
        chk("t1_rst_valid", 16'({ov_h, ov_l, busy_h, busy_l}), 16'h0);
        chk("t1_rst_code", 16'({code_h, code_l}), 16'h0);
        chk("t1_rst_pulses", 16'({zero_h, done_h, zero_l, done_l}), 16'h0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        chk("t1_no_resume", 16'({ov_h, ov_l}), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
